mcycle_ctrl: RTL and testbench
==============================

MCYCLE_CTRL -- requirements
Module: mcycle_ctrl

Interface
REQ-001 The block SHALL have parameter MEM_TIMEOUT, default 15, giving the maximum wait cycles for a memory ready before exception.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have inputs opcode [5:0], funct [5:0] (from IR, stable after IRWr), Zero (ALU compare) and mem_ready (memory handshake).
REQ-005 The block SHALL have outputs PCWr, IRWr, IMReq, DMReq, DMWr, RFWr, ASel and BSel, each 1 bit.
REQ-006 The block SHALL have outputs NPCOp [2:0], ALUOp [4:0], EXTOp [1:0], GPRSel [1:0] and WDSel [2:0], all encoded per the shared codebase encodings.
REQ-007 The block SHALL have outputs exc (1 bit), state [2:0] (debug) and instret [31:0] (retired-instruction count).

Function
REQ-008 The block SHALL implement the FSM states IF, ID, EX, MEM, WB and EXC.
REQ-009 IF SHALL hold IMReq=1 until mem_ready; in the cycle mem_ready=1 it SHALL pulse IRWr=1 and PCWr=1 with NPCOp=PLUS4, then go to ID.
REQ-010 ID SHALL last one cycle: legal opcode/funct goes to EX; illegal goes to EXC; nop (all-zero IR) goes to IF and retires.
REQ-011 EX for R/I types SHALL drive ALUOp/ASel/BSel/EXTOp from the codebase decode tables and then go to WB.
REQ-012 EX for shifts SLL/SRL/SRA SHALL drive ASel=1.
REQ-013 EX for addi/addiu SHALL drive EXTOp=SIGNED.
REQ-014 EX for beq/bne SHALL pulse PCWr with NPCOp=BRANCH when the branch is taken (beq: Zero=1; bne: Zero=0), then go to IF and retire.
REQ-015 EX for j SHALL pulse PCWr with NPCOp=JUMP, then go to IF and retire.
REQ-016 EX for jal SHALL do everything j does plus RFWr=1, GPRSel=RA (reg 31) and WDSel=FromPC.
REQ-017 EX for lw/sw SHALL compute the address with EXTOp=SIGNED and BSel=1, then go to MEM.
REQ-018 MEM SHALL hold DMReq=1, with DMWr=1 for sw only, until mem_ready.
REQ-019 On mem_ready in MEM, sw SHALL go to IF and retire; lw SHALL go to WB.
REQ-020 WB SHALL pulse RFWr=1 for one cycle and go to IF, retiring the instruction.
REQ-021 WB SHALL drive GPRSel=RD for R-type and RT otherwise.
REQ-022 WB SHALL drive WDSel=FromMEM for lw and FromALU otherwise.
REQ-023 A wait counter SHALL count cycles in IF/MEM with mem_ready=0; if it reaches MEM_TIMEOUT, the FSM SHALL go to EXC.
REQ-024 The wait counter SHALL clear on every state change.
REQ-025 EXC SHALL last one cycle with exc=1, PCWr=1 and NPCOp=EXCEPT, with no RFWr or DMWr, then go to IF.
REQ-026 instret SHALL increment by 1 on each retire, wrap from 0xFFFFFFFF to 0, and SHALL NOT increment on EXC.
REQ-027 Every strobe not listed for a state SHALL be 0 in that state.
REQ-028 Request lines SHALL never be asserted in a state other than their own.
REQ-029 At most one of PCWr, RFWr and DMWr groups SHALL be active per cycle, except the IF retire pulse and jal in EX.

Reset
REQ-030 While rstn=0, the block SHALL force state=IF, the wait counter=0, instret=0 and all strobe/select outputs to 0.
REQ-031 Reset mid-IF/MEM SHALL drop IMReq/DMReq immediately, with no write issued.
REQ-032 After rstn rises, the first IMReq SHALL appear in the first cycle.

Structure
REQ-033 State encodings, MEM_TIMEOUT default and the RA register index SHALL live in the shared control-encoding package, alongside the existing NPCOp/ALUOp/WDSel/GPRSel/EXTOp codes.
REQ-034 The opcode/funct-to-ALUOp/EXTOp decode SHALL be one combinational sub-module, mcycle_dec, instantiated once.
REQ-035 The FSM, wait counter and instret SHALL be in the top block.

Verification
REQ-036 The bench SHALL check: add with mem_ready always 1 -> IF,ID,EX,WB,IF (4 cycles), RFWr in WB with GPRSel=RD, and instret 0->1.
REQ-037 The bench SHALL check: lw with DM mem_ready delayed 3 cycles -> DMReq high 4 cycles, DMWr=0, then WB with WDSel=FromMEM; total 8 cycles.
REQ-038 The bench SHALL check: beq with Zero=1, then bne with Zero=1 -> PCWr with NPCOp=BRANCH only for beq; both retire in 3 cycles.
REQ-039 The bench SHALL check: illegal opcode 6'h3F -> exc pulse one cycle, NPCOp=EXCEPT, and instret unchanged.
REQ-040 The bench SHALL check: mem_ready held 0 in IF -> exc after exactly 15 wait cycles.
REQ-041 The bench SHALL check: rstn low during a sw in MEM -> DMReq/DMWr drop asynchronously, and instret=0 after release.
REQ-042 The bench SHALL check: instret preloaded to 0xFFFFFFFF plus one retire -> instret reads 0.

Source files
------------

// File: rtl/mcycle_ctrl_pkg.sv
// rtl/mcycle_ctrl_pkg.sv - shared control encodings for the multi-cycle controller
package mcycle_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4,
    S_EXC = 3'd5
  } state_t;

  localparam int         MEM_TIMEOUT_DEF = 15;
  localparam logic [4:0] RA_IDX          = 5'd31;

  typedef enum logic [2:0] {
    NPC_PLUS4  = 3'd0,
    NPC_BRANCH = 3'd1,
    NPC_JUMP   = 3'd2,
    NPC_JR     = 3'd3,
    NPC_EXCEPT = 3'd4
  } npc_op_t;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_AND  = 5'd2,
    ALU_OR   = 5'd3,
    ALU_XOR  = 5'd4,
    ALU_NOR  = 5'd5,
    ALU_SLT  = 5'd6,
    ALU_SLTU = 5'd7,
    ALU_SLL  = 5'd8,
    ALU_SRL  = 5'd9,
    ALU_SRA  = 5'd10,
    ALU_LUI  = 5'd11
  } alu_op_t;

  typedef enum logic [1:0] {
    EXT_ZERO   = 2'd0,
    EXT_SIGNED = 2'd1,
    EXT_HIGH   = 2'd2
  } ext_op_t;

  typedef enum logic [1:0] {
    GPR_RD = 2'd0,
    GPR_RT = 2'd1,
    GPR_RA = 2'd2
  } gpr_sel_t;

  typedef enum logic [2:0] {
    WD_ALU = 3'd0,
    WD_MEM = 3'd1,
    WD_PC  = 3'd2
  } wd_sel_t;

  typedef enum logic [2:0] {
    C_ILL    = 3'd0,
    C_NOP    = 3'd1,
    C_RTYPE  = 3'd2,
    C_ITYPE  = 3'd3,
    C_BRANCH = 3'd4,
    C_JUMP   = 3'd5,
    C_LOAD   = 3'd6,
    C_STORE  = 3'd7
  } iclass_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  function automatic logic is_shift(input logic [5:0] f);
    return (f == F_SLL) || (f == F_SRL) || (f == F_SRA);
  endfunction

endpackage

// File: rtl/mcycle_ctrl_if.sv
// rtl/mcycle_ctrl_if.sv - controller <-> datapath/memory signal bundle
interface mcycle_ctrl_if;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        Zero;
  logic        mem_ready;
  logic        PCWr;
  logic        IRWr;
  logic        IMReq;
  logic        DMReq;
  logic        DMWr;
  logic        RFWr;
  logic        ASel;
  logic        BSel;
  logic [2:0]  NPCOp;
  logic [4:0]  ALUOp;
  logic [1:0]  EXTOp;
  logic [1:0]  GPRSel;
  logic [2:0]  WDSel;
  logic        exc;
  logic [2:0]  state;
  logic [31:0] instret;
  // Debug preload of the retired-instruction counter
  logic        instret_ld;
  logic [31:0] instret_ld_val;

  modport master (
    input  opcode, funct, Zero, mem_ready, instret_ld, instret_ld_val,
    output PCWr, IRWr, IMReq, DMReq, DMWr, RFWr, ASel, BSel,
    output NPCOp, ALUOp, EXTOp, GPRSel, WDSel, exc, state, instret
  );

  modport slave (
    output opcode, funct, Zero, mem_ready, instret_ld, instret_ld_val,
    input  PCWr, IRWr, IMReq, DMReq, DMWr, RFWr, ASel, BSel,
    input  NPCOp, ALUOp, EXTOp, GPRSel, WDSel, exc, state, instret
  );
endinterface

// File: rtl/mcycle_dec.sv
// rtl/mcycle_dec.sv - opcode/funct decode to instruction class and ALU/EXT controls
module mcycle_dec
  import mcycle_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output iclass_t    cls,
  output logic       is_bne,
  output logic       is_jal,
  output alu_op_t    alu_op,
  output ext_op_t    ext_op,
  output logic       a_sel,
  output logic       b_sel
);

  always_comb begin
    cls    = C_ILL;
    is_bne = 1'b0;
    is_jal = 1'b0;
    alu_op = ALU_ADD;
    ext_op = EXT_ZERO;
    a_sel  = 1'b0;
    b_sel  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        cls   = C_RTYPE;
        a_sel = is_shift(funct);
        case (funct)
          // Only opcode/funct are visible, so an all-zero pair is taken as nop
          F_SLL:          begin cls = C_NOP; alu_op = ALU_SLL; end
          F_SRL:          alu_op = ALU_SRL;
          F_SRA:          alu_op = ALU_SRA;
          F_ADD, F_ADDU:  alu_op = ALU_ADD;
          F_SUB, F_SUBU:  alu_op = ALU_SUB;
          F_AND:          alu_op = ALU_AND;
          F_OR:           alu_op = ALU_OR;
          F_XOR:          alu_op = ALU_XOR;
          F_NOR:          alu_op = ALU_NOR;
          F_SLT:          alu_op = ALU_SLT;
          F_SLTU:         alu_op = ALU_SLTU;
          default:        cls    = C_ILL;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin cls = C_ITYPE; alu_op = ALU_ADD;  ext_op = EXT_SIGNED; b_sel = 1'b1; end
      OP_SLTI:           begin cls = C_ITYPE; alu_op = ALU_SLT;  ext_op = EXT_SIGNED; b_sel = 1'b1; end
      OP_SLTIU:          begin cls = C_ITYPE; alu_op = ALU_SLTU; ext_op = EXT_SIGNED; b_sel = 1'b1; end
      OP_ANDI:           begin cls = C_ITYPE; alu_op = ALU_AND;  b_sel = 1'b1; end
      OP_ORI:            begin cls = C_ITYPE; alu_op = ALU_OR;   b_sel = 1'b1; end
      OP_XORI:           begin cls = C_ITYPE; alu_op = ALU_XOR;  b_sel = 1'b1; end
      OP_LUI:            begin cls = C_ITYPE; alu_op = ALU_LUI;  ext_op = EXT_HIGH;   b_sel = 1'b1; end
      OP_LW:             begin cls = C_LOAD;  alu_op = ALU_ADD;  ext_op = EXT_SIGNED; b_sel = 1'b1; end
      OP_SW:             begin cls = C_STORE; alu_op = ALU_ADD;  ext_op = EXT_SIGNED; b_sel = 1'b1; end
      OP_BEQ:            begin cls = C_BRANCH; alu_op = ALU_SUB; end
      OP_BNE:            begin cls = C_BRANCH; alu_op = ALU_SUB; is_bne = 1'b1; end
      OP_J:              cls = C_JUMP;
      OP_JAL:            begin cls = C_JUMP; is_jal = 1'b1; end
      default:           cls = C_ILL;
    endcase
  end

endmodule

// File: rtl/mcycle_ctrl.sv
// rtl/mcycle_ctrl.sv - multi-cycle CPU control FSM with memory wait timeout and instret
module mcycle_ctrl
  import mcycle_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            rstn,
  mcycle_ctrl_if.master   bus
);

  localparam int WCW = $clog2(MEM_TIMEOUT + 1);

  state_t         state_q, state_d;
  logic [WCW-1:0] wait_q, wait_d;
  logic [31:0]    instret_q;
  logic           retire, waiting, timeout;

  iclass_t cls;
  logic    is_bne, is_jal, a_sel_dec, b_sel_dec;
  alu_op_t alu_dec;
  ext_op_t ext_dec;

  logic       pc_wr, ir_wr, im_req, dm_req, dm_wr, rf_wr, a_sel, b_sel, exc;
  logic [2:0] npc_op, wd_sel;
  logic [4:0] alu_op;
  logic [1:0] ext_op, gpr_sel;

  mcycle_dec u_dec (
    .opcode (bus.opcode),
    .funct  (bus.funct),
    .cls    (cls),
    .is_bne (is_bne),
    .is_jal (is_jal),
    .alu_op (alu_dec),
    .ext_op (ext_dec),
    .a_sel  (a_sel_dec),
    .b_sel  (b_sel_dec)
  );

  assign timeout = (wait_q == WCW'(MEM_TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    waiting = 1'b0;
    pc_wr   = 1'b0;
    ir_wr   = 1'b0;
    im_req  = 1'b0;
    dm_req  = 1'b0;
    dm_wr   = 1'b0;
    rf_wr   = 1'b0;
    a_sel   = 1'b0;
    b_sel   = 1'b0;
    exc     = 1'b0;
    npc_op  = NPC_PLUS4;
    alu_op  = ALU_ADD;
    ext_op  = EXT_ZERO;
    gpr_sel = GPR_RD;
    wd_sel  = WD_ALU;
    case (state_q)
      S_IF: begin
        im_req = 1'b1;
        if (bus.mem_ready) begin
          ir_wr   = 1'b1;
          pc_wr   = 1'b1;
          npc_op  = NPC_PLUS4;
          state_d = S_ID;
        end else if (timeout) begin
          state_d = S_EXC;
        end else begin
          waiting = 1'b1;
        end
      end
      S_ID: begin
        case (cls)
          C_ILL:   state_d = S_EXC;
          C_NOP:   begin state_d = S_IF; retire = 1'b1; end
          default: state_d = S_EX;
        endcase
      end
      S_EX: begin
        alu_op = alu_dec;
        ext_op = ext_dec;
        a_sel  = a_sel_dec;
        b_sel  = b_sel_dec;
        case (cls)
          C_RTYPE, C_ITYPE: state_d = S_WB;
          C_LOAD, C_STORE:  state_d = S_MEM;
          C_BRANCH: begin
            // Zero from the SUB compare: beq takes on equal, bne on not-equal
            if (bus.Zero ^ is_bne) begin
              pc_wr  = 1'b1;
              npc_op = NPC_BRANCH;
            end
            state_d = S_IF;
            retire  = 1'b1;
          end
          C_JUMP: begin
            pc_wr  = 1'b1;
            npc_op = NPC_JUMP;
            if (is_jal) begin
              rf_wr   = 1'b1;
              gpr_sel = GPR_RA;
              wd_sel  = WD_PC;
            end
            state_d = S_IF;
            retire  = 1'b1;
          end
          default: state_d = S_EXC;
        endcase
      end
      S_MEM: begin
        dm_req = 1'b1;
        dm_wr  = (cls == C_STORE);
        if (bus.mem_ready) begin
          if (cls == C_STORE) begin
            state_d = S_IF;
            retire  = 1'b1;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout) begin
          state_d = S_EXC;
        end else begin
          waiting = 1'b1;
        end
      end
      S_WB: begin
        rf_wr   = 1'b1;
        gpr_sel = (cls == C_RTYPE) ? GPR_RD : GPR_RT;
        wd_sel  = (cls == C_LOAD) ? WD_MEM : WD_ALU;
        state_d = S_IF;
        retire  = 1'b1;
      end
      S_EXC: begin
        exc     = 1'b1;
        pc_wr   = 1'b1;
        npc_op  = NPC_EXCEPT;
        state_d = S_IF;
      end
      default: state_d = S_IF;
    endcase
  end

  assign wait_d = (state_d != state_q) ? '0 :
                  (waiting ? wait_q + 1'b1 : wait_q);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IF;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      instret_q <= '0;
    end else if (bus.instret_ld) begin
      instret_q <= bus.instret_ld_val;
    end else if (retire) begin
      instret_q <= instret_q + 32'd1;
    end
  end

  // Outputs are gated by rstn so requests drop the instant reset asserts
  assign bus.PCWr    = rstn & pc_wr;
  assign bus.IRWr    = rstn & ir_wr;
  assign bus.IMReq   = rstn & im_req;
  assign bus.DMReq   = rstn & dm_req;
  assign bus.DMWr    = rstn & dm_wr;
  assign bus.RFWr    = rstn & rf_wr;
  assign bus.ASel    = rstn & a_sel;
  assign bus.BSel    = rstn & b_sel;
  assign bus.exc     = rstn & exc;
  assign bus.NPCOp   = rstn ? npc_op  : '0;
  assign bus.ALUOp   = rstn ? alu_op  : '0;
  assign bus.EXTOp   = rstn ? ext_op  : '0;
  assign bus.GPRSel  = rstn ? gpr_sel : '0;
  assign bus.WDSel   = rstn ? wd_sel  : '0;
  assign bus.state   = state_q;
  assign bus.instret = instret_q;

endmodule

// File: tb/tb_mcycle_ctrl.sv
// tb/tb_mcycle_ctrl.sv - directed self-checking bench for mcycle_ctrl
module tb_mcycle_ctrl;
  import mcycle_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  mcycle_ctrl_if bus ();

  mcycle_ctrl #(.MEM_TIMEOUT(15)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  int          cyc, dmreq_n, dmwr_n, rfwr_n, br_n, jmp_n, exc_n;
  logic [31:0] trace;
  logic [1:0]  rf_gsel, ex_ext;
  logic [2:0]  rf_wsel, exc_npc;
  logic [4:0]  ex_alu;
  logic        ex_asel, ex_bsel;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Runs one instruction from IF until the FSM is back in IF; memory answers
  // instruction fetches at once and data requests after dm_delay wait cycles.
  task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z, input int dm_delay);
    int dm_n = 0;
    cyc = 0; dmreq_n = 0; dmwr_n = 0; rfwr_n = 0; br_n = 0; jmp_n = 0; exc_n = 0;
    trace = '0; rf_gsel = '0; rf_wsel = '0; exc_npc = '0;
    ex_alu = '0; ex_asel = 1'b0; ex_bsel = 1'b0; ex_ext = '0;
    bus.opcode = op;
    bus.funct  = fn;
    bus.Zero   = z;
    do begin
      bus.mem_ready = bus.IMReq | (bus.DMReq & (dm_n == dm_delay));
      #1;
      cyc++;
      trace = {trace[27:0], 1'b0, bus.state};
      if (bus.state == S_EX) begin
        ex_alu = bus.ALUOp; ex_asel = bus.ASel; ex_bsel = bus.BSel; ex_ext = bus.EXTOp;
      end
      if (bus.DMReq) begin dmreq_n++; dm_n++; end
      if (bus.DMWr) dmwr_n++;
      if (bus.RFWr) begin rfwr_n++; rf_gsel = bus.GPRSel; rf_wsel = bus.WDSel; end
      if (bus.PCWr && bus.NPCOp == NPC_BRANCH) br_n++;
      if (bus.PCWr && bus.NPCOp == NPC_JUMP) jmp_n++;
      if (bus.exc) begin exc_n++; exc_npc = bus.NPCOp; end
      @(posedge clk); #1;
    end while (bus.state != S_IF && cyc < 40);
    bus.mem_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rstn = 1'b0;
    bus.opcode = '0; bus.funct = '0; bus.Zero = 1'b0; bus.mem_ready = 1'b0;
    bus.instret_ld = 1'b0; bus.instret_ld_val = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", bus.state, S_IF);
    check("rst_imreq", bus.IMReq, 0);
    check("rst_pcwr", bus.PCWr, 0);
    check("rst_instret", bus.instret, 0);
    #2 rstn = 1'b1;
    #1;
    check("first_imreq", bus.IMReq, 1);
    @(posedge clk); #1;

    run(OP_RTYPE, F_ADD, 1'b0, 0);
    check("add_trace", trace, 32'h0000_0124);
    check("add_cycles", cyc, 4);
    check("add_rfwr", rfwr_n, 1);
    check("add_gprsel", rf_gsel, GPR_RD);
    check("add_instret", bus.instret, 1);

    run(OP_LW, 6'h00, 1'b0, 3);
    check("lw_trace", trace, 32'h0123_3334);
    check("lw_cycles", cyc, 8);
    check("lw_dmreq", dmreq_n, 4);
    check("lw_dmwr", dmwr_n, 0);
    check("lw_wdsel", rf_wsel, WD_MEM);
    check("lw_gprsel", rf_gsel, GPR_RT);
    check("lw_ext", ex_ext, EXT_SIGNED);
    check("lw_bsel", ex_bsel, 1);
    check("lw_instret", bus.instret, 2);

    run(OP_BEQ, 6'h00, 1'b1, 0);
    check("beq_cycles", cyc, 3);
    check("beq_branch", br_n, 1);
    check("beq_instret", bus.instret, 3);
    run(OP_BNE, 6'h00, 1'b1, 0);
    check("bne_cycles", cyc, 3);
    check("bne_branch", br_n, 0);
    check("bne_instret", bus.instret, 4);

    run(6'h3F, 6'h00, 1'b0, 0);
    check("ill_trace", trace, 32'h0000_0015);
    check("ill_exc", exc_n, 1);
    check("ill_npc", exc_npc, NPC_EXCEPT);
    check("ill_rfwr", rfwr_n, 0);
    check("ill_instret", bus.instret, 4);

    run(OP_RTYPE, F_SRA, 1'b0, 0);
    check("sra_asel", ex_asel, 1);
    check("sra_alu", ex_alu, ALU_SRA);
    check("sra_gprsel", rf_gsel, GPR_RD);

    run(OP_ADDI, 6'h00, 1'b0, 0);
    check("addi_ext", ex_ext, EXT_SIGNED);
    check("addi_bsel", ex_bsel, 1);
    check("addi_gprsel", rf_gsel, GPR_RT);
    check("addi_cycles", cyc, 4);

    run(OP_JAL, 6'h00, 1'b0, 0);
    check("jal_cycles", cyc, 3);
    check("jal_jump", jmp_n, 1);
    check("jal_rfwr", rfwr_n, 1);
    check("jal_gprsel", rf_gsel, GPR_RA);
    check("jal_wdsel", rf_wsel, WD_PC);

    run(OP_SW, 6'h00, 1'b0, 0);
    check("sw_trace", trace, 32'h0000_0123);
    check("sw_dmwr", dmwr_n, 1);
    check("sw_rfwr", rfwr_n, 0);

    run(OP_RTYPE, F_SLL, 1'b0, 0);
    check("nop_cycles", cyc, 2);
    check("nop_instret", bus.instret, 9);

    n = 0;
    bus.mem_ready = 1'b0;
    while (!bus.exc && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("tmo_wait_cycles", n, 15);
    check("tmo_npc", bus.NPCOp, NPC_EXCEPT);
    check("tmo_pcwr", bus.PCWr, 1);
    check("tmo_rfwr", bus.RFWr, 0);
    @(posedge clk); #1;
    check("tmo_back_if", bus.state, S_IF);
    check("tmo_instret", bus.instret, 9);

    bus.opcode = OP_SW;
    n = 0;
    while (!bus.DMReq && n < 10) begin
      bus.mem_ready = bus.IMReq;
      @(posedge clk); #1;
      n++;
    end
    bus.mem_ready = 1'b0;
    #1;
    check("swr_reach_mem", n, 3);
    check("swr_dmreq_on", bus.DMReq, 1);
    check("swr_dmwr_on", bus.DMWr, 1);
    #1 rstn = 1'b0;
    #1;
    check("swr_dmreq_drop", bus.DMReq, 0);
    check("swr_dmwr_drop", bus.DMWr, 0);
    check("swr_imreq_drop", bus.IMReq, 0);
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;
    #1;
    check("swr_instret", bus.instret, 0);
    check("swr_state", bus.state, S_IF);
    check("swr_imreq", bus.IMReq, 1);
    @(posedge clk); #1;

    bus.instret_ld = 1'b1;
    bus.instret_ld_val = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    bus.instret_ld = 1'b0;
    check("wrap_preload", bus.instret, 32'hFFFF_FFFF);
    run(OP_RTYPE, F_ADD, 1'b0, 0);
    check("wrap_instret", bus.instret, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
